// File: rtl/byte_pkg.sv
// Shared types for the byte demux: FSM state encoding and select-index width.
package byte_pkg;

  localparam int unsigned MAX_MEMS = 16;
  localparam int unsigned SEL_W    = 5;

  // One code beyond the largest legal target index marks "no target".
  localparam logic [SEL_W-1:0] SEL_UNMAPPED = SEL_W'(MAX_MEMS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } state_e;

endpackage

// File: rtl/byte_addr_decode.sv
// Combinational address decoder: lowest-index region whose masked compare matches.
module byte_addr_decode
  import byte_pkg::*;
#(
  parameter int unsigned                  MEMS      = 4,
  parameter int unsigned                  ADDR_SIZE = 32,
  parameter logic [MEMS*ADDR_SIZE-1:0]    BASE_ADDR = '0,
  parameter logic [MEMS*ADDR_SIZE-1:0]    ADDR_MASK = '0
) (
  input  logic [ADDR_SIZE-1:0] addr_i,
  output logic [SEL_W-1:0]     sel_o,
  output logic                 hit_o
);

  always_comb begin
    sel_o = SEL_UNMAPPED;
    hit_o = 1'b0;
    for (int unsigned i = 0; i < MEMS; i++) begin
      if (!hit_o &&
          ((addr_i & ADDR_MASK[i*ADDR_SIZE +: ADDR_SIZE]) == BASE_ADDR[i*ADDR_SIZE +: ADDR_SIZE])) begin
        sel_o = SEL_W'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_demux_n.sv
// One-master to MEMS-target request demux with hold watchdog and error reporting.
// Define BYTE_DEMUX_N_ERRCNT_EN to build the saturating error counter on errCount_o.
module byte_demux_n
  import byte_pkg::*;
#(
  parameter int unsigned               MEMS      = 4,
  parameter int unsigned               DATA_BYTE = 4,
  parameter int unsigned               ADDR_SIZE = 32,
  parameter logic [MEMS*ADDR_SIZE-1:0] BASE_ADDR = {32'h0000_3000, 32'h0000_2000,
                                                    32'h0000_1000, 32'h0000_0000},
  parameter logic [MEMS*ADDR_SIZE-1:0] ADDR_MASK = {4{32'h0000_F000}},
  parameter int unsigned               TIMEOUT   = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     useEnable_i,
  input  logic                     useIsWrite_i,
  input  logic [DATA_BYTE-1:0]     useWriteMask_i,
  input  logic [ADDR_SIZE-1:0]     useAddr_i,
  input  logic [DATA_BYTE*8-1:0]   useWriteData_i,
  output logic [DATA_BYTE*8-1:0]   useReadData_o,
  output logic                     useHold_o,
  output logic                     useError_o,
  output logic [MEMS-1:0]          memEnable_o,
  output logic [MEMS-1:0]          memIsWrite_o,
  output logic [DATA_BYTE-1:0]     memWriteMask_o [MEMS],
  output logic [ADDR_SIZE-1:0]     memAddr_o      [MEMS],
  output logic [DATA_BYTE*8-1:0]   memWriteData_o [MEMS],
  input  logic [DATA_BYTE*8-1:0]   memReadData_i  [MEMS],
  input  logic [MEMS-1:0]          memHold_i,
  output logic [15:0]              errCount_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  rd_sel_q, rd_sel_d;
  logic              err_q, err_d;

  logic [SEL_W-1:0]  sel_c;
  logic              hit_c;
  logic              sel_hold_c;
  logic              abort_c;
  logic              accept_c;
  logic [CNT_W-1:0]  hold_next_c;
  logic              timeout_hit_c;

  byte_addr_decode #(
    .MEMS      (MEMS),
    .ADDR_SIZE (ADDR_SIZE),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_MASK (ADDR_MASK)
  ) u_decode (
    .addr_i (useAddr_i),
    .sel_o  (sel_c),
    .hit_o  (hit_c)
  );

  // Request fields fan out unchanged; only the enable is steered.
  always_comb begin
    sel_hold_c = 1'b0;
    for (int unsigned i = 0; i < MEMS; i++) begin
      memIsWrite_o[i]   = useIsWrite_i;
      memWriteMask_o[i] = useWriteMask_i;
      memAddr_o[i]      = useAddr_i;
      memWriteData_o[i] = useWriteData_i;
      memEnable_o[i]    = useEnable_i && !abort_c && (sel_c == SEL_W'(i));
      if (sel_c == SEL_W'(i)) begin
        sel_hold_c = memHold_i[i];
      end
    end
  end

  assign abort_c   = (state_q == ST_ABORT);
  assign useHold_o = useEnable_i && hit_c && sel_hold_c && !abort_c;
  // The abort cycle completes the stalled request with an error.
  assign accept_c  = abort_c || (useEnable_i && !useHold_o);

  assign hold_next_c   = ((state_q == ST_WAIT) ? cnt_q : '0) + CNT_W'(1);
  assign timeout_hit_c = (TIMEOUT != 0) && (hold_next_c >= CNT_W'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    rd_sel_d = rd_sel_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (useHold_o) begin
          if (timeout_hit_c) begin
            state_d = ST_ABORT;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = (TIMEOUT != 0) ? hold_next_c : '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (accept_c) begin
      rd_sel_d = (abort_c || !hit_c) ? SEL_UNMAPPED : sel_c;
      err_d    = abort_c || !hit_c;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_sel_q <= SEL_UNMAPPED;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_sel_q <= rd_sel_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    useReadData_o = '0;
    for (int unsigned i = 0; i < MEMS; i++) begin
      if (rd_sel_q == SEL_W'(i)) begin
        useReadData_o = memReadData_i[i];
      end
    end
  end

  assign useError_o = err_q;

`ifdef BYTE_DEMUX_N_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign errCount_o = err_cnt_q;
`else
  assign errCount_o = '0;
`endif

endmodule

// File: doc/byte_demux_n.md
BYTE_DEMUX_N -- requirements
Module: byte_demux_n

Interface
REQ-001 SHALL have parameter MEMS, default 4, meaning number of target ports (1..16).
REQ-002 SHALL have parameter DATA_BYTE, default 4, meaning data width in bytes.
REQ-003 SHALL have parameter ADDR_SIZE, default 32, meaning address width.
REQ-004 SHALL have parameter BASE_ADDR and ADDR_MASK, both packed MEMS*ADDR_SIZE, meaning per-target region base and compare mask (entry i at bits [i*ADDR_SIZE +: ADDR_SIZE]).
REQ-005 SHALL have parameter TIMEOUT, default 0, meaning max consecutive hold cycles before abort (0 = watchdog off).
REQ-006 SHALL have port clk_i  input  1  the one clock; all state on its rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports useEnable_i/useIsWrite_i  input  1 each  user request and direction.
REQ-009 SHALL have ports useWriteMask_i  input  DATA_BYTE, useAddr_i  input  ADDR_SIZE, useWriteData_i  input  DATA_BYTE*8.
REQ-010 SHALL have port useReadData_o  output  DATA_BYTE*8  read data of the last accepted request.
REQ-011 SHALL have port useHold_o  output  1  stall to user.
REQ-012 SHALL have port useError_o  output  1  error flag, aligned with read data.
REQ-013 SHALL have ports memEnable_o/memIsWrite_o  output  1 [MEMS], memWriteMask_o/memAddr_o/memWriteData_o  output  widths as user side [MEMS].
REQ-014 SHALL have ports memReadData_i  input  DATA_BYTE*8 [MEMS], memHold_i  input  1 [MEMS].
REQ-015 SHALL have port errCount_o  output  16  saturating error count.

Function
REQ-016 SHALL decode: target i matches when (useAddr_i & MASK[i]) == BASE[i]; lowest matching index wins; no match = unmapped.
REQ-017 SHALL forward IsWrite/WriteMask/Addr/WriteData unchanged to all targets; memEnable_o[i] = useEnable_i && sel==i && state!=ABORT.
REQ-018 SHALL drive useHold_o = memHold_i[sel] combinationally when mapped and enabled; 0 for unmapped, idle, or ABORT.
REQ-019 SHALL define acceptance as a cycle with useEnable_i=1 and useHold_o=0.
REQ-020 SHALL register the selected index (or UNMAPPED) on acceptance; useReadData_o = memReadData_i[rdSel] from the next cycle until the next acceptance; all-zero when rdSel is UNMAPPED.
REQ-021 SHALL assert useError_o for exactly the cycle after an unmapped or aborted acceptance, else 0.
REQ-022 SHALL implement FSM IDLE/WAIT/ABORT: IDLE->WAIT when enabled, mapped, hold=1; WAIT->IDLE on acceptance or useEnable_i=0; WAIT->ABORT when hold persisted TIMEOUT cycles (TIMEOUT>0); ABORT->IDLE after one cycle.
REQ-023 SHALL count consecutive hold cycles in a counter of clog2(TIMEOUT+1) bits, cleared on leaving WAIT; ABORT is an acceptance (useHold_o=0, memEnable_o all 0).
REQ-024 SHALL give back-to-back requests full throughput: acceptance possible every cycle, no bubble.
REQ-025 SHALL make a write to an unmapped address have no side effect other than the error.

Reset
REQ-026 SHALL, while rst_i=1 (asynchronously), set state IDLE, hold counter 0, rdSel UNMAPPED, useError_o 0, errCount_o 0; useReadData_o then 0.
REQ-027 SHALL abandon any in-flight WAIT on reset with no error recorded.

Configuration
REQ-028 SHALL, with macro BYTE_DEMUX_N_ERRCNT_EN defined, increment errCount_o on each error acceptance, saturating at 16'hFFFF.
REQ-029 SHALL, without BYTE_DEMUX_N_ERRCNT_EN, tie errCount_o to 0 and instantiate no counter flops.

Structure
REQ-030 SHALL place FSM state enum and UNMAPPED select encoding in shared package byte_pkg.
REQ-031 SHALL place the address decoder in sub-module byte_addr_decode (combinational, outputs sel index and hit).

Verification
REQ-032 MEMS=4, BASE {0x0,0x1000,0x2000,0x3000}, MASK 0xF000: read 0x2004 -> memEnable_o=4'b0100, next cycle useReadData_o=memReadData_i[2], useError_o=0.
REQ-033 Read 0x9000 -> useHold_o=0 same cycle, next cycle useReadData_o=0, useError_o=1, errCount_o=1 (macro on).
REQ-034 TIMEOUT=3, target 1 holds forever -> 3 hold cycles, ABORT cycle with memEnable_o=0 and useHold_o=0, then useError_o=1.
REQ-035 Back-to-back reads 0x0004, 0x3008 with no hold -> data from target 0 then target 3 on consecutive cycles.
REQ-036 rst_i asserted mid-WAIT -> state IDLE, errCount_o=0, useError_o=0 immediately, no abort.
